if_fetch: RTL and testbench

// Instruction-fetch stage: owns the PC, fetches words from instruction memory over a req/ack handshake,
// and drives the registered pc/inst pair consumed by the decode stage (IF/ID boundary).

---
 rtl/if_fetch_pkg.sv | 22 ++
 rtl/if_fetch_if.sv | 11 +
 rtl/if_fetch_id_reg.sv | 58 +++++
 rtl/if_fetch.sv | 115 +++++++++++
 tb/tb_if_fetch.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Covers the fetch FSM encoding, the {pc, inst} word type and the reset level.
package if_fetch_pkg;

    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic        RST_ENABLE = 1'b0;

    typedef logic [31:0] inst_addr_t;
    typedef logic [31:0] inst_t;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_REQ  = 2'd1,
        FETCH_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_word_t;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and memory.
// The master issues req/addr; the slave answers with ack and rdata in the same cycle.
interface if_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_id_reg.sv
// IF/ID pipeline register.
// Flush clears everything; stall freezes it; otherwise it loads a word or becomes a NOP.
module if_id_reg
    import if_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        load_i,
    input  fetch_word_t load_word_i,
    output inst_addr_t  id_pc_o,
    output inst_t       id_inst_o,
    output logic        id_valid_o
);

    inst_addr_t pc_q,    pc_d;
    inst_t      inst_q,  inst_d;
    logic       valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (flush_i) begin
            pc_d    = ZERO_WORD;
            inst_d  = ZERO_WORD;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                pc_d    = load_word_i.pc;
                inst_d  = load_word_i.inst;
                valid_d = 1'b1;
            end else begin
                // Bubble: pc is left as-is so decode still sees the last address.
                inst_d  = ZERO_WORD;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            pc_q    <= ZERO_WORD;
            inst_q  <= ZERO_WORD;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
        end
    end

    assign id_pc_o    = pc_q;
    assign id_inst_o  = inst_q;
    assign id_valid_o = valid_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single-outstanding fetch FSM, stall buffer and flush/redirect.
// Feeds the IF/ID register that drives the decode stage.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic [31:0]   new_pc_i,
    if_fetch_if.master    imem,
    output logic [31:0]   id_pc_o,
    output logic [31:0]   id_inst_o,
    output logic          id_valid_o
);

    fetch_state_e state_q, state_d;
    inst_addr_t   pc_q, pc_d;
    inst_addr_t   redirect_q, redirect_d;
    logic         drop_q, drop_d;
    fetch_word_t  buf_q, buf_d;
    logic         load;
    fetch_word_t  load_word;

    assign imem.req  = (state_q == FETCH_REQ);
    assign imem.addr = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = redirect_q;
        drop_d     = drop_q;
        buf_d      = buf_q;
        load       = 1'b0;
        load_word  = buf_q;

        unique case (state_q)
            FETCH_IDLE: state_d = FETCH_REQ;
            FETCH_REQ: begin
                if (imem.ack) begin
                    if (drop_q) begin
                        // Stale word from before a flush: swallow it and fetch the target.
                        drop_d = 1'b0;
                        pc_d   = redirect_q;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                        if (!stall_i) begin
                            load      = 1'b1;
                            load_word = '{pc: pc_q, inst: imem.rdata};
                            state_d   = FETCH_IDLE;
                        end else begin
                            buf_d   = '{pc: pc_q, inst: imem.rdata};
                            state_d = FETCH_HOLD;
                        end
                    end
                end
            end
            FETCH_HOLD: begin
                if (!stall_i) begin
                    load      = 1'b1;
                    load_word = buf_q;
                    state_d   = FETCH_REQ;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase

        if (flush_i) begin
            load    = 1'b0;
            buf_d   = '0;
            state_d = (state_q == FETCH_IDLE) ? FETCH_IDLE : FETCH_REQ;
            if (state_q == FETCH_REQ && !imem.ack) begin
                // Request is still open: keep its address on the bus, park the target.
                drop_d     = 1'b1;
                redirect_d = new_pc_i;
                pc_d       = pc_q;
            end else begin
                drop_d = 1'b0;
                pc_d   = new_pc_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= PC_RESET;
            redirect_q <= ZERO_WORD;
            drop_q     <= 1'b0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            drop_q     <= drop_d;
            buf_q      <= buf_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .load_i      (load),
        .load_word_i (load_word),
        .id_pc_o     (id_pc_o),
        .id_inst_o   (id_inst_o),
        .id_valid_o  (id_valid_o)
    );

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: per-cycle vector table with a fetch scoreboard,
// plus hand sequences for reset mid-fetch and PC wrap-around.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = 32'h0;
    logic [31:0] id_pc_o, id_inst_o;
    logic        id_valid_o;
    logic [31:0] w_id_pc, w_id_inst;
    logic        w_id_valid;

    int checks = 0;
    int errors = 0;

    if_fetch_if bus ();
    if_fetch_if w_bus ();

    always #5 clk = ~clk;

    if_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .new_pc_i   (new_pc_i),
        .imem       (bus),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_valid_o (id_valid_o)
    );

    // Second instance starting just below the top of the address space, zero-wait memory.
    assign w_bus.ack   = w_bus.req;
    assign w_bus.rdata = 32'h0000_0013;

    if_fetch #(.PC_RESET(32'hFFFF_FFFC), .PC_STEP(32'd4)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (1'b0),
        .flush_i    (1'b0),
        .new_pc_i   (32'h0),
        .imem       (w_bus),
        .id_pc_o    (w_id_pc),
        .id_inst_o  (w_id_inst),
        .id_valid_o (w_id_valid)
    );

    typedef struct {
        logic        stall;
        logic        flush;
        logic [31:0] npc;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        push;
        logic        pop;
    } vec_t;

    vec_t        vecs[$];
    logic [63:0] sb[$];
    logic [31:0] wq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic fl, input logic [31:0] npc,
                       input logic ack, input logic [31:0] rd,
                       input logic ereq, input logic [31:0] eaddr,
                       input logic ev, input logic [31:0] epc, input logic [31:0] einst,
                       input logic push, input logic pop);
        vec_t v;
        v = '{st, fl, npc, ack, rd, ereq, eaddr, ev, epc, einst, push, pop};
        vecs.push_back(v);
    endtask

    initial begin
        logic [63:0] e;

        // stall flush npc ack rdata | req addr | valid pc inst | push pop
        add(0,0,0,          0,0,            0,32'h000, 0,32'h000,0,            0,0);
        add(0,0,0,          1,32'h34010001, 1,32'h000, 1,32'h000,32'h34010001, 1,1);
        add(0,0,0,          0,0,            0,32'h004, 0,32'h000,0,            0,0);
        add(0,0,0,          1,32'h34020002, 1,32'h004, 1,32'h004,32'h34020002, 1,1);
        add(0,0,0,          0,0,            0,32'h008, 0,32'h004,0,            0,0);
        add(1,0,0,          1,32'h00000013, 1,32'h008, 0,32'h004,0,            1,0);
        add(1,0,0,          0,0,            0,32'h00C, 0,32'h004,0,            0,0);
        add(1,0,0,          0,0,            0,32'h00C, 0,32'h004,0,            0,0);
        add(0,0,0,          0,0,            0,32'h00C, 1,32'h008,32'h00000013, 0,1);
        add(0,0,0,          0,0,            1,32'h00C, 0,32'h008,0,            0,0);
        add(0,0,0,          1,32'h11111111, 1,32'h00C, 1,32'h00C,32'h11111111, 1,1);
        add(0,0,0,          0,0,            0,32'h010, 0,32'h00C,0,            0,0);
        add(0,1,32'h100,    0,0,            1,32'h010, 0,32'h000,0,            0,0);
        add(0,0,0,          0,0,            1,32'h010, 0,32'h000,0,            0,0);
        add(0,0,0,          0,0,            1,32'h010, 0,32'h000,0,            0,0);
        add(0,0,0,          0,0,            1,32'h010, 0,32'h000,0,            0,0);
        add(0,0,0,          1,32'hDEADBEEF, 1,32'h010, 0,32'h000,0,            0,0);
        add(0,0,0,          1,32'h22222222, 1,32'h100, 1,32'h100,32'h22222222, 1,1);
        add(0,0,0,          0,0,            0,32'h104, 0,32'h100,0,            0,0);
        add(1,0,0,          1,32'h33333333, 1,32'h104, 0,32'h100,0,            0,0);
        add(1,1,32'h200,    0,0,            0,32'h108, 0,32'h000,0,            0,0);
        add(0,0,0,          0,0,            1,32'h200, 0,32'h000,0,            0,0);
        add(0,0,0,          1,32'h44444444, 1,32'h200, 1,32'h200,32'h44444444, 1,1);
        add(0,0,0,          0,0,            0,32'h204, 0,32'h200,0,            0,0);
        add(0,0,0,          1,32'h55555555, 1,32'h204, 1,32'h204,32'h55555555, 1,1);
        add(1,0,0,          0,0,            0,32'h208, 1,32'h204,32'h55555555, 0,0);
        add(1,0,0,          0,0,            1,32'h208, 1,32'h204,32'h55555555, 0,0);
        add(0,0,0,          0,0,            1,32'h208, 0,32'h204,0,            0,0);
        add(0,1,32'h302,    1,32'h66666666, 1,32'h208, 0,32'h000,0,            0,0);
        add(0,0,0,          1,32'h77777777, 1,32'h302, 1,32'h302,32'h77777777, 1,1);

        bus.ack   = 1'b0;
        bus.rdata = 32'h0;

        // Reset held for three edges; ack asserted to show it is ignored.
        bus.ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_req", {31'b0, bus.req}, 32'h0);
            chk("rst_valid", {31'b0, id_valid_o}, 32'h0);
            chk("rst_pc", id_pc_o, 32'h0);
            chk("rst_inst", id_inst_o, 32'h0);
            $display("reset cycle %0d: req=%b valid=%b", i, bus.req, id_valid_o);
        end
        bus.ack = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            stall_i   = vecs[i].stall;
            flush_i   = vecs[i].flush;
            new_pc_i  = vecs[i].npc;
            bus.ack   = vecs[i].ack;
            bus.rdata = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_req", i), {31'b0, bus.req}, {31'b0, vecs[i].exp_req});
            chk($sformatf("v%0d_addr", i), bus.addr, vecs[i].exp_addr);
            if (vecs[i].push) sb.push_back({vecs[i].exp_addr, vecs[i].rdata});
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid", i), {31'b0, id_valid_o}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("v%0d_pc", i), id_pc_o, vecs[i].exp_pc);
            chk($sformatf("v%0d_inst", i), id_inst_o, vecs[i].exp_inst);
            if (vecs[i].pop) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL v%0d_sb: got delivery expected empty scoreboard", i);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("v%0d_sb_pc", i), id_pc_o, e[63:32]);
                    chk($sformatf("v%0d_sb_inst", i), id_inst_o, e[31:0]);
                end
            end
            $display("vec %0d: stall=%b flush=%b ack=%b addr=%h -> id_pc=%h id_inst=%h valid=%b",
                     i, vecs[i].stall, vecs[i].flush, vecs[i].ack, vecs[i].exp_addr,
                     id_pc_o, id_inst_o, id_valid_o);
        end
        chk("sb_empty", sb.size(), 32'd0);

        // Reset asserted while a request is open: request must fall, state restarts.
        @(negedge clk);
        stall_i = 1'b0; flush_i = 1'b0; bus.ack = 1'b0;
        #1;
        chk("mid_idle_req", {31'b0, bus.req}, 32'h0);
        @(posedge clk);
        @(negedge clk); #1;
        chk("mid_req", {31'b0, bus.req}, 32'h1);
        chk("mid_addr", bus.addr, 32'h306);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_req", {31'b0, bus.req}, 32'h0);
        chk("mid_rst_valid", {31'b0, id_valid_o}, 32'h0);
        chk("mid_rst_pc", id_pc_o, 32'h0);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("mid_c1_req", {31'b0, bus.req}, 32'h0);
        chk("mid_c1_addr", bus.addr, 32'h0);
        @(posedge clk);
        @(negedge clk); #1;
        chk("mid_c2_req", {31'b0, bus.req}, 32'h1);
        chk("mid_c2_addr", bus.addr, 32'h0);
        $display("reset mid-fetch: restart req=%b addr=%h", bus.req, bus.addr);

        // Wrap-around on the second instance.
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (w_bus.req) wq.push_back(w_bus.addr);
        end
        chk("wrap_count", (wq.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
        if (wq.size() >= 2) begin
            chk("wrap_first", wq[0], 32'hFFFF_FFFC);
            chk("wrap_second", wq[1], 32'h0000_0000);
            $display("wrap: first addr=%h second addr=%h", wq[0], wq[1]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
